// File: rtl/nou_pkg.sv
// Shared helpers for NOU pipeline blocks: width calculations derived from FIFO depth.
package nou_pkg;

    // Pointer width for a power-of-two depth; indexes 0..depth-1.
    function automatic int PTR_W(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Count width able to hold 0..depth inclusive.
    function automatic int CNT_W(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dff.sv
// Library enable flop without reset, used for datapath storage.
module dff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         g,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // NOTE: storage is deliberately not reset; control state guarantees it is never read before written.
    always_ff @(posedge clk) begin
        if (g) begin
            q <= d;
        end
    end

endmodule

// File: rtl/dffr.sv
// Library enable flop with asynchronous active-low reset to value R.
module dffr #(
    parameter int               W = 1,
    parameter logic [W-1:0]     R = '0
) (
    input  logic         clk,
    input  logic         rn,
    input  logic         g,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rn) begin
        if (!rn) begin
            q <= R;
        end else if (g) begin
            q <= d;
        end
    end

endmodule

// File: rtl/nou_fifo_ctrl.sv
// Pointer, occupancy and flag logic for the NOU synchronous FIFO.
module nou_fifo_ctrl
    import nou_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int AFULL_TH = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       rn,
    input  logic                       clr,
    input  logic                       wr_vld,
    input  logic                       rd_rdy,
    output logic                       wr_rdy,
    output logic                       rd_vld,
    output logic                       push,
    output logic [PTR_W(DEPTH)-1:0]    wr_ptr,
    output logic [PTR_W(DEPTH)-1:0]    rd_ptr,
    output logic [CNT_W(DEPTH)-1:0]    cnt,
    output logic                       afull
);

    localparam int PW = PTR_W(DEPTH);
    localparam int CW = CNT_W(DEPTH);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AF   = CW'(AFULL_TH);

    logic          pop;
    logic          wr_ptr_en;
    logic          rd_ptr_en;
    logic          cnt_en;
    logic [PW-1:0] wr_ptr_d;
    logic [PW-1:0] rd_ptr_d;
    logic [CW-1:0] cnt_d;

    // Handshake flags depend only on registered count and clr, never on the partner's valid/ready.
    assign wr_rdy = (cnt != CNT_FULL) & ~clr;
    assign rd_vld = (cnt != '0) & ~clr;
    assign push   = wr_vld & wr_rdy;
    assign pop    = rd_vld & rd_rdy;
    assign afull  = (cnt >= CNT_AF);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        wr_ptr_d  = wr_ptr + PW'(1);
        rd_ptr_d  = rd_ptr + PW'(1);
        cnt_d     = cnt;
        wr_ptr_en = push;
        rd_ptr_en = pop;
        cnt_en    = push ^ pop;
        if (push && !pop) begin
            cnt_d = cnt + CW'(1);
        end else if (pop && !push) begin
            cnt_d = cnt - CW'(1);
        end
        if (clr) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            cnt_d     = '0;
            wr_ptr_en = 1'b1;
            rd_ptr_en = 1'b1;
            cnt_en    = 1'b1;
        end
    end

    dffr #(.W(PW), .R('0)) u_wr_ptr (
        .clk (clk),
        .rn  (rn),
        .g   (wr_ptr_en),
        .d   (wr_ptr_d),
        .q   (wr_ptr)
    );

    dffr #(.W(PW), .R('0)) u_rd_ptr (
        .clk (clk),
        .rn  (rn),
        .g   (rd_ptr_en),
        .d   (rd_ptr_d),
        .q   (rd_ptr)
    );

    dffr #(.W(CW), .R('0)) u_cnt (
        .clk (clk),
        .rn  (rn),
        .g   (cnt_en),
        .d   (cnt_d),
        .q   (cnt)
    );

endmodule

// File: rtl/nou_sync_fifo.sv
// Single-clock first-word-fall-through FIFO between NOU pipeline stages.
module nou_sync_fifo
    import nou_pkg::*;
#(
    parameter int W        = 8,
    parameter int DEPTH    = 4,
    parameter int AFULL_TH = DEPTH - 1
) (
    input  logic                    clk,
    input  logic                    rn,
    input  logic                    clr,
    input  logic                    wr_vld,
    output logic                    wr_rdy,
    input  logic [W-1:0]            wr_data,
    output logic                    rd_vld,
    input  logic                    rd_rdy,
    output logic [W-1:0]            rd_data,
    output logic [CNT_W(DEPTH)-1:0] cnt,
    output logic                    afull
);

    localparam int PW = PTR_W(DEPTH);

    logic          push;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [W-1:0]  mem [DEPTH];

    nou_fifo_ctrl #(
        .DEPTH    (DEPTH),
        .AFULL_TH (AFULL_TH)
    ) u_ctrl (
        .clk    (clk),
        .rn     (rn),
        .clr    (clr),
        .wr_vld (wr_vld),
        .rd_rdy (rd_rdy),
        .wr_rdy (wr_rdy),
        .rd_vld (rd_vld),
        .push   (push),
        .wr_ptr (wr_ptr),
        .rd_ptr (rd_ptr),
        .cnt    (cnt),
        .afull  (afull)
    );

    for (genvar i = 0; i < DEPTH; i++) begin : g_mem
        dff #(.W(W)) u_ent (
            .clk (clk),
            .g   (push & (wr_ptr == PW'(i))),
            .d   (wr_data),
            .q   (mem[i])
        );
    end

    // Head is read straight from storage, so a beat written at edge N shows at N+1 with no bypass.
    assign rd_data = mem[rd_ptr];

endmodule
